// File: rtl/wb_mem_responder_if.sv
// Wishbone-style request/response bundle between the core bus master and the
// memory responder. The master drives the request; the slave answers with a
// registered ack, read data and a busy flag.
interface wb_mem_responder_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32
);
    logic [ADDR_SIZE-1:0] Wb_addr;
    logic                 Wb_cs;
    logic                 Wb_we;
    logic [WORD_SIZE-1:0] Wb_wdata;
    logic [WORD_SIZE-1:0] Wb_rdata;
    logic                 Wb_ack;
    logic                 Busy;

    modport master (
        output Wb_addr, Wb_cs, Wb_we, Wb_wdata,
        input  Wb_rdata, Wb_ack, Busy
    );

    modport slave (
        input  Wb_addr, Wb_cs, Wb_we, Wb_wdata,
        output Wb_rdata, Wb_ack, Busy
    );
endinterface

// File: rtl/wb_mem_responder.sv
// Single-port word memory behind a Wishbone-style handshake. One request is
// accepted at a time, held for WAIT_STATES cycles, then completed with a
// one-cycle ack. Out-of-range accesses are acked; reads return ERR_DATA and
// writes are dropped. Dropping Wb_cs during the wait phase abandons the request.
module wb_mem_responder #(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   ADDR_SIZE   = 32,
    parameter int                   DEPTH       = 256,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter int                   WAIT_STATES = 1,
    parameter logic [WORD_SIZE-1:0] ERR_DATA    = WORD_SIZE'(32'hDEAD_BEEF)
) (
    input logic                Clk,
    input logic                Rst,
    wb_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    // Counter reload value; unused when there are no wait states.
    localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_SIZE-1:0] cap_addr;
    logic                 cap_we;
    logic [WORD_SIZE-1:0] cap_wdata;
    logic                 ack_q;
    logic [WORD_SIZE-1:0] rdata_q;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    // In IDLE the live bus is the request being accepted this edge; once
    // busy, only the captured copy counts so initiator changes are ignored.
    logic [ADDR_SIZE-1:0] sel_addr;
    logic                 sel_we;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic [ADDR_SIZE-1:0] off;
    logic                 in_range;
    logic [IDX_W-1:0]     idx;
    logic                 enter_ack;
    logic                 mem_we;
    logic [WORD_SIZE-1:0] rd_val;

    // Request select, address decode and the ACK-entry condition.
    always_comb begin
        sel_addr  = (state == S_IDLE) ? bus.Wb_addr  : cap_addr;
        sel_we    = (state == S_IDLE) ? bus.Wb_we    : cap_we;
        sel_wdata = (state == S_IDLE) ? bus.Wb_wdata : cap_wdata;
        off       = sel_addr - BASE_ADDR;
        // Unsigned offset: anything at or beyond DEPTH words (or below base,
        // which wraps high) has a nonzero bit above the word index.
        in_range  = (off >> (IDX_W + 2)) == '0;
        idx       = off[IDX_W+1:2];
        enter_ack = bus.Wb_cs &&
                    (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0)));
        // Gate with reset so a held request cannot commit while in reset.
        mem_we    = Rst && enter_ack && sel_we && in_range;
        rd_val    = sel_we   ? '0 :
                    in_range ? mem[idx] : ERR_DATA;
    end

    // Memory array; contents survive reset.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[idx] <= sel_wdata;
    end

    // Request FSM with registered ack / read data.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            case (state)
                S_IDLE: begin
                    if (bus.Wb_cs) begin
                        cap_addr  <= bus.Wb_addr;
                        cap_we    <= bus.Wb_we;
                        cap_wdata <= bus.Wb_wdata;
                        if (WAIT_STATES == 0) begin
                            state   <= S_ACK;
                            ack_q   <= 1'b1;
                            rdata_q <= rd_val;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'(WS_M1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.Wb_cs) begin
                        state <= S_IDLE;
                    end else if (cnt == 4'd0) begin
                        state   <= S_ACK;
                        ack_q   <= 1'b1;
                        rdata_q <= rd_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Wb_ack   = ack_q;
    assign bus.Wb_rdata = rdata_q;
    assign bus.Busy     = (state != S_IDLE);

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (0, 1 and 3 wait states) share
// clock and reset. A driver issues requests and pushes the expected ack cycle
// and read data into a per-instance queue; a negedge monitor pops and compares.
module tb_wb_mem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
    localparam logic [31:0] OOR   = BASE + DEPTH * 4;

    logic tb_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic [2:0]  cs, we, ack, busy;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];

    int unsigned cyc = 0;
    always @(posedge tb_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
            wb_mem_responder_if #(.WORD_SIZE(32), .ADDR_SIZE(32)) bus ();
            assign bus.Wb_cs    = cs[g];
            assign bus.Wb_we    = we[g];
            assign bus.Wb_addr  = addr[g];
            assign bus.Wb_wdata = wdata[g];
            assign ack[g]       = bus.Wb_ack;
            assign busy[g]      = bus.Busy;
            assign rdata[g]     = bus.Wb_rdata;
            wb_mem_responder #(
                .WORD_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH),
                .BASE_ADDR(BASE), .WAIT_STATES(WS), .ERR_DATA(ERR)
            ) u_dut (
                .Clk(tb_clk),
                .Rst(rst_n),
                .bus(bus)
            );
        end
    endgenerate

    function automatic int ws_of(int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // Reference memory: plain word array per instance with a written flag.
    logic [31:0] mdl   [3][DEPTH];
    bit          mdl_v [3][DEPTH];

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    exp_t        sbq [3][$];
    int unsigned last_ack [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Apply one completed transaction to the model; return expected read data.
    function automatic void predict(int k, bit w, logic [31:0] a, logic [31:0] d,
                                    output logic [31:0] rd, output bit known);
        logic [31:0] off;
        int          i;
        off   = a - BASE;
        rd    = 32'h0;
        known = 1'b0;
        if (off >= DEPTH * 4) begin
            rd    = ERR;
            known = !w;
        end else begin
            i = int'(off / 4);
            if (w) begin
                mdl[k][i]   = d;
                mdl_v[k][i] = 1'b1;
            end else begin
                rd    = mdl[k][i];
                known = mdl_v[k][i];
            end
        end
    endfunction

    // Monitor: every ack must match the oldest expectation; rdata idles at 0.
    always @(negedge tb_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ack[k] === 1'b1) begin
                if (sbq[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack dut%0d: ack=1 at cycle %0d, want no ack", k, cyc);
                end else begin
                    exp_t e;
                    e = sbq[k].pop_front();
                    check($sformatf("ack_cycle dut%0d", k), cyc, e.cyc);
                    if (e.chk) check($sformatf("rdata dut%0d", k), rdata[k], e.data);
                end
            end else begin
                check($sformatf("rdata_idle dut%0d", k), rdata[k], 32'h0);
            end
        end
    end

    // Cycle at which the next edge-sampled request is taken: if we are in the
    // ACK cycle, the edge leaving ACK ignores cs and the following edge takes it.
    function automatic int unsigned sample_cyc(int k);
        return cyc + ((last_ack[k] == cyc) ? 2 : 1);
    endfunction

    // Full transaction. keep=1 leaves cs high after the ack so the caller can
    // issue a back-to-back request on the same instance.
    task automatic txn(int k, bit w, logic [31:0] a, logic [31:0] d, bit keep);
        exp_t        e;
        int unsigned cn;
        bit          got;
        got   = 1'b0;
        cn    = sample_cyc(k);
        e.cyc = cn + ws_of(k);
        predict(k, w, a, d, e.data, e.chk);
        sbq[k].push_back(e);
        cs[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge tb_clk);
            if (ack[k]) got = 1'b1;
            else if (cyc >= cn) begin
                // Request already captured: scramble to prove it is ignored.
                addr[k] = $urandom; wdata[k] = $urandom; we[k] = 1'($urandom % 2);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d: no ack within 40 cycles, want ack at cycle %0d", k, e.cyc);
            sbq[k].delete();
        end else begin
            last_ack[k] = cyc;
            if (!keep) begin cs[k] = 1'b0; we[k] = 1'b0; end
        end
    endtask

    // Write whose cs drops so that edge sample+j sees cs low (j <= wait states).
    task automatic abort_wr(int k, logic [31:0] a, logic [31:0] d, int j);
        int unsigned cn;
        bit          seen;
        seen = 1'b0;
        cn   = sample_cyc(k);
        cs[k] = 1'b1; we[k] = 1'b1; addr[k] = a; wdata[k] = d;
        for (int t = 0; t < 8 && cyc < cn + j - 1; t++) @(negedge tb_clk);
        cs[k] = 1'b0; we[k] = 1'b0;
        repeat (ws_of(k) + 3) begin
            @(negedge tb_clk);
            if (ack[k]) seen = 1'b1;
        end
        check($sformatf("abort_no_ack dut%0d", k), 32'(seen), 32'h0);
    endtask

    // Write interrupted by reset while waiting.
    task automatic reset_mid(int k, logic [31:0] a, logic [31:0] d);
        int unsigned cn;
        cn = sample_cyc(k);
        cs[k] = 1'b1; we[k] = 1'b1; addr[k] = a; wdata[k] = d;
        for (int t = 0; t < 8 && cyc < cn; t++) @(negedge tb_clk);
        #2 rst_n = 1'b0;
        #1;
        check($sformatf("rstmid_busy dut%0d", k), 32'(busy[k]), 32'h0);
        check($sformatf("rstmid_ack dut%0d", k), 32'(ack[k]), 32'h0);
        cs[k] = 1'b0; we[k] = 1'b0;
        @(negedge tb_clk);
        check($sformatf("rstmid_busy_hold dut%0d", k), 32'(busy[k]), 32'h0);
        rst_n = 1'b1;
        @(negedge tb_clk);
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned p;
        p = $urandom % 10;
        if (p == 0) return OOR + ($urandom % 64);
        if (p == 1) return BASE + 32'h3FC + ($urandom % 4);
        return BASE + (($urandom % 8) * 4) + ($urandom % 4);
    endfunction

    initial begin
        int k;
        int nk;
        bit keep;
        cs = '0; we = '0;
        for (int i = 0; i < 3; i++) begin addr[i] = 32'h40; wdata[i] = 32'hCAFE_0000; end

        // Reset held with cs asserted: outputs stay quiet.
        rst_n = 1'b0;
        cs    = 3'b111; we = 3'b111;
        repeat (3) begin
            @(negedge tb_clk);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rst_ack dut%0d", i), 32'(ack[i]), 32'h0);
                check($sformatf("rst_rdata dut%0d", i), rdata[i], 32'h0);
                check($sformatf("rst_busy dut%0d", i), 32'(busy[i]), 32'h0);
            end
        end
        cs = '0; we = '0;
        rst_n = 1'b1;
        @(negedge tb_clk);

        // One wait state: write then read 0x1FC.
        txn(1, 1'b1, 32'h1FC, 32'hFFFF_F000, 1'b0);
        txn(1, 1'b0, 32'h1FC, 32'h0, 1'b0);

        // Zero wait states, cs held through ack, back-to-back requests.
        txn(0, 1'b1, 32'h20, 32'hA5A5_0001, 1'b1);
        txn(0, 1'b0, 32'h20, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h22, 32'h0, 1'b0);

        // Out-of-range read/write on every instance; mem[0] must survive.
        for (int i = 0; i < 3; i++) begin
            txn(i, 1'b1, BASE, 32'h0BAD_0000 + i, 1'b0);
            txn(i, 1'b0, OOR, 32'h0, 1'b0);
            txn(i, 1'b1, OOR, 32'h5555_AAAA, 1'b0);
            txn(i, 1'b0, BASE, 32'h0, 1'b0);
        end

        // Abandoned writes leave old data.
        txn(2, 1'b1, 32'h10, 32'h0000_0010, 1'b0);
        abort_wr(2, 32'h10, 32'h1234_5678, 2);
        txn(2, 1'b0, 32'h10, 32'h0, 1'b0);
        txn(1, 1'b1, 32'h14, 32'h0000_0014, 1'b0);
        abort_wr(1, 32'h14, 32'h8765_4321, 1);
        txn(1, 1'b0, 32'h14, 32'h0, 1'b0);

        // Reset during the wait phase of a write.
        txn(1, 1'b1, 32'h30, 32'h0000_0030, 1'b0);
        reset_mid(1, 32'h30, 32'hBEEF_0030);
        txn(1, 1'b0, 32'h30, 32'h0, 1'b0);
        txn(2, 1'b1, 32'h34, 32'h0000_0034, 1'b0);
        reset_mid(2, 32'h34, 32'hBEEF_0034);
        txn(2, 1'b0, 32'h34, 32'h0, 1'b0);

        // Preload the random working set, then random traffic.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 8; j++) txn(i, 1'b1, BASE + j * 4, $urandom, 1'b0);
            txn(i, 1'b1, BASE + 32'h3FC, $urandom, 1'b0);
        end
        k = int'($urandom % 3);
        for (int n = 0; n < 80; n++) begin
            nk   = int'($urandom % 3);
            keep = (nk == k) && ($urandom % 2 == 1);
            txn(k, 1'($urandom % 2), rnd_addr(), $urandom, keep);
            if (!keep && ($urandom % 3 == 0)) repeat ($urandom % 3) @(negedge tb_clk);
            k = nk;
        end
        cs = '0;

        repeat (6) @(negedge tb_clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("sb_drained dut%0d", i), sbq[i].size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
